// File: rtl/slew_rate_limiter.sv
// Slew-rate limiter: steps a registered output toward a rail-clamped target
// by at most SLEW_STEP per clock, with settle tracking and clip/fault status.
module slew_rate_limiter #(
  parameter int WIDTH         = 16,
  parameter int SLEW_STEP     = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] target_in,
  input  logic signed [WIDTH-1:0] vcc,
  input  logic signed [WIDTH-1:0] vee,
  output logic signed [WIDTH-1:0] out,
  output logic                    slewing,
  output logic                    settled,
  output logic                    clip_hi,
  output logic                    clip_lo,
  output logic                    rail_fault
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic signed [WIDTH:0] STEP = (WIDTH+1)'(SLEW_STEP);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SLEW,
    SETTLE,
    LOCKED
  } state_t;

  state_t state, state_nx;
  logic signed [WIDTH-1:0] target_q;
  logic signed [WIDTH-1:0] eff;
  logic signed [WIDTH-1:0] out_step;
  logic signed [WIDTH-1:0] out_nx;
  logic signed [WIDTH:0]   diff;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    fault;
  logic                    run;

  assign fault = vee > vcc;
  assign run   = en && !fault;

  always_comb begin
    eff = target_q;
    if (eff < vee) eff = vee;
    if (eff > vcc) eff = vcc;
  end

  // One extra bit so the distance between the rails never wraps.
  assign diff = $signed({eff[WIDTH-1], eff})
              - $signed({out[WIDTH-1], out});

  always_comb begin
    unique case (1'b1)
      diff > STEP:  out_step = out + WIDTH'(SLEW_STEP);
      diff < -STEP: out_step = out - WIDTH'(SLEW_STEP);
      default:      out_step = eff;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = out;
    if (!run) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nx   = '0;
          state_nx = (out != eff) ? SLEW : SETTLE;
        end
        SLEW: begin
          out_nx = out_step;
          if (out_step == eff) begin
            state_nx = SETTLE;
            cnt_nx   = '0;
          end
        end
        SETTLE: begin
          out_nx = out_step;
          if (out != eff) begin
            state_nx = SLEW;
            cnt_nx   = '0;
          end else if (cnt == LAST) begin
            state_nx = LOCKED;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        LOCKED: begin
          out_nx = out_step;
          if (out != eff) begin
            state_nx = SLEW;
            cnt_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out        <= '0;
      target_q   <= '0;
      slewing    <= 1'b0;
      settled    <= 1'b0;
      clip_hi    <= 1'b0;
      clip_lo    <= 1'b0;
      rail_fault <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      out        <= out_nx;
      if (en) target_q <= target_in;
      slewing    <= state_nx == SLEW;
      settled    <= state_nx == LOCKED;
      clip_hi    <= !fault && (target_q > vcc);
      clip_lo    <= !fault && (target_q < vee);
      rail_fault <= fault;
    end
  end

endmodule

// File: tb/tb_slew_rate_limiter.sv
// Bench for slew_rate_limiter: behavioural model feeds a scoreboard queue,
// plus directed checks of the hand-derived values for each scenario.
module tb_slew_rate_limiter;

  localparam int W    = 16;
  localparam int STEP = 64;
  localparam int SC   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [W-1:0] target_in = '0;
  logic signed [W-1:0] vcc = '0;
  logic signed [W-1:0] vee = '0;
  logic signed [W-1:0] out;
  logic slewing, settled, clip_hi, clip_lo, rail_fault;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [W+4:0] obs_t;
  obs_t sb[$];

  int m_out, m_tq, m_cnt, m_st;

  always #5 clk = ~clk;

  slew_rate_limiter #(
    .WIDTH(W),
    .SLEW_STEP(STEP),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .target_in(target_in),
    .vcc(vcc),
    .vee(vee),
    .out(out),
    .slewing(slewing),
    .settled(settled),
    .clip_hi(clip_hi),
    .clip_lo(clip_lo),
    .rail_fault(rail_fault)
  );

  function automatic obs_t observed();
    return {out, slewing, settled, clip_hi, clip_lo, rail_fault};
  endfunction

  task automatic model_reset();
    m_out = 0;
    m_tq  = 0;
    m_cnt = 0;
    m_st  = 0;
  endtask

  // States: 0 idle, 1 slew, 2 settle, 3 locked.
  task automatic drive(input bit e, input int t, input int hi, input int lo);
    int eff, d, nx, ns;
    bit f, ch, cl;
    en = e;
    target_in = W'(t);
    vcc = W'(hi);
    vee = W'(lo);
    f  = lo > hi;
    ch = !f && (m_tq > hi);
    cl = !f && (m_tq < lo);
    nx = m_out;
    ns = 0;
    if (e && !f) begin
      eff = (m_tq < lo) ? lo : m_tq;
      eff = (eff > hi) ? hi : eff;
      d = eff - m_out;
      if (m_st != 0) begin
        if (d > STEP) nx = m_out + STEP;
        else if (d < -STEP) nx = m_out - STEP;
        else nx = eff;
      end
      case (m_st)
        0: begin
          m_cnt = 0;
          ns = (m_out != eff) ? 1 : 2;
        end
        1: begin
          ns = 1;
          if (nx == eff) begin ns = 2; m_cnt = 0; end
        end
        2: begin
          ns = 2;
          if (m_out != eff) begin ns = 1; m_cnt = 0; end
          else if (m_cnt == SC - 1) ns = 3;
          else m_cnt++;
        end
        default: begin
          ns = 3;
          if (m_out != eff) begin ns = 1; m_cnt = 0; end
        end
      endcase
    end else begin
      m_cnt = 0;
    end
    if (e) m_tq = t;
    m_out = nx;
    m_st  = ns;
    sb.push_back({W'(nx), ns == 1, ns == 3, ch, cl, f});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g;
    model_reset();
    @(posedge clk);
    #1;
    g = observed();
    n_cmp++;
    if (g !== '0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", g);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    obs_t g, x;
    int o[10];
    bit sl[10], st[10];
    int eo[5] = '{0, 64, 128, 192, 200};
    for (int i = 0; i < 10; i++) begin
      drive(1, 200, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL ramp[%0d] got %h want %h", i, g, x);
      end
      o[i] = int'(out);
      sl[i] = slewing;
      st[i] = settled;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (o[i] != eo[i]) begin
        n_bad++;
        $display("FAIL ramp_out[%0d] got %0d want %0d", i, o[i], eo[i]);
      end
    end
    n_cmp++;
    if ({sl[0], sl[1], sl[2], sl[3], sl[4]} !== 5'b01110) begin
      n_bad++;
      $display("FAIL ramp_slewing got %b want 01110",
               {sl[0], sl[1], sl[2], sl[3], sl[4]});
    end
    n_cmp++;
    if ({st[7], st[8]} !== 2'b01) begin
      n_bad++;
      $display("FAIL ramp_settled got %b want 01", {st[7], st[8]});
    end
  endtask

  task automatic test_down();
    obs_t g, x;
    int lo_seen = 32767;
    bit any_cl = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(1, -1000, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL down[%0d] got %h want %h", i, g, x);
      end
      if (int'(out) < lo_seen) lo_seen = int'(out);
      any_cl |= clip_lo;
    end
    n_cmp++;
    if (lo_seen != -1000 || int'(out) != -1000 || any_cl || !settled) begin
      n_bad++;
      $display("FAIL down_end got min=%0d out=%0d clip_lo=%b set=%b want -1000 -1000 0 1",
               lo_seen, out, any_cl, settled);
    end
  endtask

  task automatic test_clip();
    obs_t g, x;
    int hi_seen = -32768;
    for (int i = 0; i < 35; i++) begin
      drive(1, 32767, 500, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL clip[%0d] got %h want %h", i, g, x);
      end
      if (int'(out) > hi_seen) hi_seen = int'(out);
    end
    n_cmp++;
    if (hi_seen != 500 || int'(out) != 500 || !clip_hi || !settled) begin
      n_bad++;
      $display("FAIL clip_end got max=%0d out=%0d clip_hi=%b set=%b want 500 500 1 1",
               hi_seen, out, clip_hi, settled);
    end
  endtask

  task automatic test_extremes();
    obs_t g, x;
    int prev;
    bit bad_dir = 1'b0;
    for (int i = 0; i < 515; i++) begin
      drive(1, 32767, 32767, -32768);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL top[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (int'(out) != 32767 || !settled || clip_hi) begin
      n_bad++;
      $display("FAIL top_end got out=%0d set=%b clip_hi=%b want 32767 1 0",
               out, settled, clip_hi);
    end
    prev = int'(out);
    for (int i = 0; i < 1035; i++) begin
      drive(1, -32768, 32767, -32768);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL bottom[%0d] got %h want %h", i, g, x);
      end
      if (int'(out) > prev) bad_dir = 1'b1;
      prev = int'(out);
    end
    n_cmp++;
    if (int'(out) != -32768 || !settled || bad_dir) begin
      n_bad++;
      $display("FAIL bottom_end got out=%0d set=%b rose=%b want -32768 1 0",
               out, settled, bad_dir);
    end
  endtask

  task automatic test_rail_move();
    obs_t g, x;
    int o[9];
    bit sl[9], st[9];
    int eo[4] = '{236, 172, 108, 100};
    for (int i = 0; i < 530; i++) begin
      drive(1, 300, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL to300[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (int'(out) != 300 || !settled) begin
      n_bad++;
      $display("FAIL to300_end got out=%0d set=%b want 300 1", out, settled);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 300, 100, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL railin[%0d] got %h want %h", i, g, x);
      end
      o[i] = int'(out);
      sl[i] = slewing;
      st[i] = settled;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (o[i] != eo[i]) begin
        n_bad++;
        $display("FAIL railin_out[%0d] got %0d want %0d", i, o[i], eo[i]);
      end
    end
    n_cmp++;
    if ({sl[0], sl[2], sl[3], st[6], st[7]} !== 5'b11001) begin
      n_bad++;
      $display("FAIL railin_flags got %b want 11001",
               {sl[0], sl[2], sl[3], st[6], st[7]});
    end
  endtask

  task automatic test_abort_and_en();
    obs_t g, x;
    int frozen;
    for (int i = 0; i < 4; i++) begin
      drive(1, -900, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL preabort[%0d] got %h want %h", i, g, x);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    g = observed();
    n_cmp++;
    if (g !== '0) begin
      n_bad++;
      $display("FAIL async_reset got %h want 0", g);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, -900, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL postreset[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (int'(out) != -320 || !slewing) begin
      n_bad++;
      $display("FAIL postreset_out got %0d sl=%b want -320 1", out, slewing);
    end
    frozen = int'(out);
    for (int i = 0; i < 3; i++) begin
      drive(0, 500, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL en_off[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (int'(out) != frozen || slewing || settled) begin
      n_bad++;
      $display("FAIL en_freeze got out=%0d sl=%b set=%b want %0d 0 0",
               out, slewing, settled, frozen);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, -900, 1000, -1000);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL en_on[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (int'(out) != frozen - STEP || !slewing) begin
      n_bad++;
      $display("FAIL en_resume got out=%0d sl=%b want %0d 1",
               out, slewing, frozen - STEP);
    end
  endtask

  task automatic test_fault();
    obs_t g, x;
    int frozen;
    frozen = int'(out);
    for (int i = 0; i < 3; i++) begin
      drive(1, -900, -10, 10);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL fault[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (!rail_fault || int'(out) != frozen || slewing || clip_lo) begin
      n_bad++;
      $display("FAIL fault_hold got rf=%b out=%0d sl=%b cl=%b want 1 %0d 0 0",
               rail_fault, out, slewing, clip_lo, frozen);
    end
    for (int i = 0; i < 15; i++) begin
      drive(1, -900, -10, -10);
      tick();
      x = sb.pop_front();
      g = observed();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL unfault[%0d] got %h want %h", i, g, x);
      end
    end
    n_cmp++;
    if (rail_fault || int'(out) <= frozen) begin
      n_bad++;
      $display("FAIL fault_clear got rf=%b out=%0d want 0 above %0d",
               rail_fault, out, frozen);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_down();
    test_clip();
    test_extremes();
    test_rail_move();
    test_abort_and_en();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slew_rate_limiter.md
Name: slew_rate_limiter

Overview:
- Downstream stage of the op-amp top level: consumes the signed 16-bit amplifier output and produces a rate-limited, rail-clamped drive value.
- Models finite op-amp slew rate: output moves toward the sampled target by at most SLEW_STEP per clock.
- Reports slewing, settled and clip status to the system controller.

Parameters:
- WIDTH, 16, data width of all signed sample and rail buses.
- SLEW_STEP, 64, maximum magnitude change of out per clock (unsigned, 1..2^(WIDTH-1)-1).
- SETTLE_CYCLES, 4, consecutive cycles out must equal the effective target before settled asserts (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; 0 holds out and target_q, forces IDLE.
- target_in  input  WIDTH signed  amplifier output to follow (from pin6_output).
- vcc  input  WIDTH signed  upper rail.
- vee  input  WIDTH signed  lower rail.
- out  output  WIDTH signed  rate-limited output, registered.
- slewing  output  1  state is SLEW.
- settled  output  1  state is LOCKED.
- clip_hi  output  1  target_q above vcc this cycle, registered.
- clip_lo  output  1  target_q below vee this cycle, registered.
- rail_fault  output  1  vee > vcc, registered.

Behaviour:
- Reset (async, rst_n=0): out=0, target_q=0, settle count=0, state IDLE, slewing=settled=clip_hi=clip_lo=rail_fault=0. Reset mid-slew aborts immediately; the first edge after release behaves as from IDLE.
- Sampling: when en=1, target_q <= target_in every edge. out reacts to target_q on the following edge. Minimum latency, target_in to out, is 2 clocks for a change <= SLEW_STEP.
- Effective target: eff = min(max(target_q, vee), vcc), computed combinationally from the live rails.
  - clip_hi <= (target_q > vcc).
  - clip_lo <= (target_q < vee).
- Step rule: diff = eff - out, computed at WIDTH+1 bits (no wrap).
  - |diff| <= SLEW_STEP: out <= eff.
  - Otherwise: out <= out + SLEW_STEP*sign(diff).
  - out can never overflow and never leaves [vee, vcc] once inside. If the rails move inward past out, out steps toward the new rail at SLEW_STEP per clock, not instantly.
- Rail fault: vee > vcc sets rail_fault <= 1. While it persists: out holds, state forced to IDLE, clip flags 0. On clearing, resume from IDLE.
- States, with en=1 and no fault unless noted:
  - IDLE: out holds, count=0. Next state is SLEW if out != eff, else SETTLE.
  - SLEW: out steps each cycle. When the step lands on eff, go to SETTLE with count=0.
  - SETTLE: count increments each cycle out == eff. If out != eff (target or rail moved), go to SLEW and clear count. When count reaches SETTLE_CYCLES-1 with out == eff, go to LOCKED.
  - LOCKED: out == eff held. Any change making out != eff goes to SLEW and clears count.
  - Any state with en=0 or rail_fault: go to IDLE. out and target_q hold; slewing=settled=0.
- Flags are registered from the next state, so slewing and settled align with the out value of the same cycle.
- A target change equal to the current out while in SLEW goes to SETTLE, with no overshoot.
- Simultaneous target change and en deassert: en wins; target_q is not updated.

Test Plan:
- Reset, then en=1, vcc=1000, vee=-1000, target_in=200 held: target_q=200 after edge 1. out = 64, 128, 192, 200 on edges 2-5. slewing=1 on edges 2-4. settled=1 four cycles after out reaches 200.
- From LOCKED at 200, target_in=-1000: out decreases by 64 per clock to -1000 exactly with no undershoot. clip_lo stays 0.
- target_in=32767, vcc=500: out ramps to 500 and stops. clip_hi=1 while target_q > 500. settled asserts. No wrap at 32767 or -32768.
- out=300 LOCKED, vcc lowered to 100: out = 236, 172, 108, 100. slewing then settled.
- Mid-slew, assert rst_n=0 asynchronously (not at an edge): out=0 and all flags 0 immediately. Mid-slew en=0: out freezes, state IDLE; en=1 resumes stepping.
- vee=10, vcc=-10: rail_fault=1 next edge, out holds, state IDLE. Restore vee=-10: fault clears and stepping resumes.
